// File: rtl/stream_filter3x3.sv
// Streaming 3x3 window filter (pass/gauss/sharpen/dilate) built from two line buffers over valid/ready.
// Output registered one cycle after the accept that completes a window; in_ready falls with a stalled output.
module stream_filter3x3 #(
    parameter int DW    = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pixel,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] win [3][3];
    logic [DW-1:0] nw  [3][3];

    logic accept, last_px, win_ok;

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign last_px  = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));

    // Window as it will look after this accept; kernels see the fresh column.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = win[r][1];
            nw[r][1] = win[r][2];
        end
        nw[0][2] = lb1[col];
        nw[1][2] = lb0[col];
        nw[2][2] = in_pixel;
    end

    logic [DW+3:0]        gsum;
    logic [DW+3:0]        c_ext;
    logic signed [DW+3:0] sharp;
    logic [DW-1:0]        mx;
    logic [DW-1:0]        kout;

    always_comb begin
        gsum = (DW+4)'(nw[0][0]) + ((DW+4)'(nw[0][1]) << 1) + (DW+4)'(nw[0][2])
             + ((DW+4)'(nw[1][0]) << 1) + ((DW+4)'(nw[1][1]) << 2) + ((DW+4)'(nw[1][2]) << 1)
             + (DW+4)'(nw[2][0]) + ((DW+4)'(nw[2][1]) << 1) + (DW+4)'(nw[2][2]);
        c_ext = (DW+4)'(nw[1][1]);
        // Modular arithmetic is exact here: the true result always fits DW+4 signed bits.
        sharp = signed'(c_ext + (c_ext << 2) - (DW+4)'(nw[0][1]) - (DW+4)'(nw[2][1])
                        - (DW+4)'(nw[1][0]) - (DW+4)'(nw[1][2]));
        mx = nw[0][0];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (nw[r][c] > mx) mx = nw[r][c];
        case (mode_q)
            2'd0:    kout = nw[1][1];
            2'd1:    kout = gsum[DW+3:4];
            2'd2: begin
                if (sharp[DW+3])           kout = '0;
                else if (|sharp[DW+2:DW])  kout = '1;
                else                       kout = sharp[DW-1:0];
            end
            default: kout = mx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= '0;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    state  <= RUN;
                    mode_q <= mode;
                    col    <= '0;
                    row    <= '0;
                end
                RUN:   if (accept && last_px) state <= FLUSH;
                FLUSH: if (out_valid && out_ready && out_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                win <= nw;
            end
            if (accept && win_ok) begin
                out_valid <= 1'b1;
                out_pixel <= kout;
                out_last  <= last_px;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_filter3x3.sv
// Directed bench for stream_filter3x3: a 4x4 instance for kernel/reset checks, an 8x5 instance for stalls.
module tb_stream_filter3x3;
    logic       clk = 1'b0;
    logic       rst, en, in_valid, out_ready, sel;
    logic [1:0] mode;
    logic [7:0] in_pixel;

    logic       en_a, in_ready_a, out_valid_a, out_last_a, busy_a, done_a;
    logic       en_b, in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [7:0] out_pixel_a, out_pixel_b;

    logic       in_ready_m, out_valid_m, out_last_m, busy_m, done_m;
    logic [7:0] out_pixel_m;

    int tests = 0, fails = 0;
    int pix[$];
    int expq[$];
    int first_at, cycles;

    always #5 clk = ~clk;

    assign en_a = en && !sel;
    assign en_b = en && sel;
    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_last_m  = sel ? out_last_b  : out_last_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign done_m      = sel ? done_b      : done_a;
    assign out_pixel_m = sel ? out_pixel_b : out_pixel_a;

    stream_filter3x3 #(.DW(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pixel(in_pixel),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pixel(out_pixel_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a));

    stream_filter3x3 #(.DW(8), .IMG_W(8), .IMG_H(5)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pixel(in_pixel),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pixel(out_pixel_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_img(input int base, input int centre);
        pix = {};
        for (int i = 0; i < 16; i++) pix.push_back(base);
        pix[5] = centre;
    endtask

    function automatic int px(input int r, input int c, input int w);
        return pix[r * w + c];
    endfunction

    function automatic int gauss(input int r, input int c, input int w);
        int s;
        s = px(r-1, c-1, w) + 2*px(r-1, c, w) + px(r-1, c+1, w)
          + 2*px(r, c-1, w) + 4*px(r, c, w) + 2*px(r, c+1, w)
          + px(r+1, c-1, w) + 2*px(r+1, c, w) + px(r+1, c+1, w);
        return s >> 4;
    endfunction

    task automatic run_frame(input int m, input bit rnd, input bit toggle);
        int n, idx, k, nexp;
        bit acc, xf, held_v, held_last;
        logic [7:0] held_pix;
        n = sel ? 40 : 16;
        nexp = expq.size();
        idx = 0; k = 0; cycles = 0; held_v = 0; held_pix = 0; held_last = 0; first_at = -1;
        in_valid = 0; out_ready = 1;
        @(negedge clk); mode = 2'(m); en = 1;
        @(negedge clk); en = 0;
        check("busy_run", busy_m, 1);
        while (k < nexp && cycles < 3000) begin
            if (held_v) begin
                check("hold_pixel", out_pixel_m, held_pix);
                check("hold_last", out_last_m, held_last);
                check("hold_valid", out_valid_m, 1);
            end
            in_valid  = (idx < n) && (!rnd || ($urandom % 4 != 0));
            in_pixel  = (idx < n) ? 8'(pix[idx]) : 8'd0;
            out_ready = !rnd || ($urandom % 2 == 0);
            if (toggle) mode = mode ^ 2'b11;
            #1;
            acc = in_valid && in_ready_m;
            xf  = out_valid_m && out_ready;
            if (xf) begin
                check($sformatf("out_pixel[%0d]", k), out_pixel_m, expq[k]);
                check($sformatf("out_last[%0d]", k), out_last_m, (k == nexp - 1));
                if (k == 0) first_at = idx;
                k++;
            end
            held_v = out_valid_m && !out_ready;
            held_pix = out_pixel_m;
            held_last = out_last_m;
            @(posedge clk);
            if (acc) idx++;
            cycles++;
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        check("outputs_seen", k, nexp);
        check("done_pulse", done_m, 1);
        check("idle_after", busy_m, 0);
        check("valid_clear", out_valid_m, 0);
        @(negedge clk);
        check("done_single", done_m, 0);
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; in_valid = 0; in_pixel = 0; out_ready = 1; sel = 0;
        #12;
        check("rst_in_ready", in_ready_m, 0);
        check("rst_out_valid", out_valid_m, 0);
        check("rst_out_last", out_last_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        check("rst_out_pixel", out_pixel_m, 0);
        @(negedge clk); rst = 0;

        // Pass-through, full rate: latency and throughput
        pix = {}; for (int i = 0; i < 16; i++) pix.push_back(i);
        expq = {5, 6, 9, 10};
        run_frame(0, 0, 0);
        check("first_out_after_accepts", first_at, 11);
        check("full_rate_cycles", cycles, 17);

        set_img(100, 100); expq = {100, 100, 100, 100}; run_frame(1, 0, 0);
        set_img(0, 255);   expq = {63, 31, 31, 15};     run_frame(1, 0, 0);
        set_img(10, 200);  expq = {255, 0, 0, 10};      run_frame(2, 0, 0);
        set_img(50, 0);    expq = {0, 100, 100, 50};    run_frame(2, 0, 0);
        set_img(50, 60);   expq = {100, 40, 40, 50};    run_frame(2, 0, 0);

        // Dilate with mode wiggling during the frame
        pix = {}; for (int i = 0; i < 16; i++) pix.push_back(i);
        expq = {10, 11, 14, 15};
        run_frame(3, 0, 1);

        // 8x5 Gaussian with random stalls on both sides
        sel = 1;
        pix = {}; for (int i = 0; i < 40; i++) pix.push_back(int'($urandom_range(0, 255)));
        expq = {};
        for (int r = 1; r < 4; r++)
            for (int c = 1; c < 7; c++)
                expq.push_back(gauss(r, c, 8));
        run_frame(1, 1, 0);
        check("model_count", expq.size(), 18);

        // Abort mid-frame
        sel = 0;
        @(negedge clk); mode = 0; en = 1;
        @(negedge clk); en = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1; in_pixel = 8'(i);
            @(negedge clk);
        end
        check("pre_abort_ready", in_ready_m, 1);
        in_valid = 0;
        #2 rst = 1;
        #1;
        check("abort_in_ready", in_ready_m, 0);
        check("abort_busy", busy_m, 0);
        check("abort_out_valid", out_valid_m, 0);
        check("abort_out_last", out_last_m, 0);
        check("abort_done", done_m, 0);
        check("abort_out_pixel", out_pixel_m, 0);
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_m, 0);
        check("abort_stays_idle", busy_m, 0);

        pix = {}; for (int i = 0; i < 16; i++) pix.push_back(100 + i);
        expq = {105, 106, 109, 110};
        run_frame(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_filter3x3.md
# stream_filter3x3

Parametrised streaming 3x3 window filter: successor of the fixed-size, memory-fed parallel filter. Accepts a raster-order pixel stream over a valid/ready handshake, builds the 3x3 window internally with two line buffers, and emits one filtered pixel per interior image position. The kernel is run-time selectable. It sits between the pixel source (camera/DMA reader) and the frame writer.

## Interface
- DW, 8: pixel width in bits.
- IMG_W, 64: image width in pixels, >= 3.
- IMG_H, 64: image height in pixels, >= 3.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  frame start pulse; sampled only in IDLE.
- mode  in  2  kernel select; latched when `en` is accepted.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_pixel  in  DW  input pixel, raster order.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_pixel  out  DW  filtered pixel.
- out_last  out  1  marks the final output pixel of the frame.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse when the frame completes.

## Operation
- FSM: IDLE, RUN, FLUSH.
  - IDLE -> RUN on `en`: latch `mode`, clear `col`/`row`.
  - RUN -> FLUSH when input pixel (IMG_H-1, IMG_W-1) is accepted.
  - FLUSH -> IDLE when the `out_last` beat transfers; `done` pulses in that same cycle.
- Accept condition: `in_valid && in_ready`. `in_ready = (state==RUN) && (!out_valid || out_ready)`.
- On each accept:
  - Advance `col`; wrap to 0 at IMG_W-1 and increment `row`.
  - Line buffers: lb1[col] <= lb0[col]; lb0[col] <= in_pixel. Each is an IMG_W-deep array.
  - Window shifts one column left; the new right column is {lb1[col], lb0[col], in_pixel}, top to bottom.
- The window is valid when the accepted pixel has row >= 2 and col >= 2. Its centre is image pixel (row-1, col-1). Only interior pixels are produced: (IMG_W-2)*(IMG_H-2) outputs per frame.
- The window column-shift and output generation use the same accept. A valid window loads `out_pixel` and sets `out_valid`.
- `out_last` is set with the output produced by the final input pixel.
- Kernels, with c = centre, n/s/e/w = 4-neighbours, all unsigned inputs:
  - mode 0, pass-through: out = c.
  - mode 1, Gaussian [1 2 1; 2 4 2; 1 2 1]: DW+4-bit sum, out = sum >> 4 (truncate).
  - mode 2, sharpen: 5c - n - s - e - w in DW+4-bit signed; clamp below 0 to 0 and above 2^DW-1 to 2^DW-1.
  - mode 3, dilate: out = max of the 9 window pixels.
- `mode` changes during RUN/FLUSH are ignored. `en` outside IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, col = row = 0, all window registers = 0.
  - in_ready = out_valid = out_last = busy = done = 0, out_pixel = 0.
  - Line buffer contents are not reset. Every read value is written earlier in the same frame before it is used.
- Latency: output registered 1 cycle after the accept of input pixel (r+1, c+1) for centre (r, c).
- Throughput: 1 pixel/cycle when out_ready is held high.
- Backpressure:
  - out_valid, out_pixel and out_last hold stable while out_valid && !out_ready.
  - in_ready drops in the same cycle (combinational from out_ready), so no input is lost or dropped.
- Input stall: with in_valid low, no counters or window registers change. Output drains normally.
- Simultaneous output transfer and new valid window in one cycle: the new output replaces the old; out_valid stays 1.
- Rows 0-1 and columns 0-1 produce no output but are still accepted at full rate.
- Async reset mid-frame: everything returns to IDLE immediately and the partial output is discarded. The next frame needs a new `en`.
- `done` never pulses for an aborted frame.

## Test plan
- IMG_W=IMG_H=4, mode 0, input 0..15, out_ready=1 -> outputs 5, 6, 9, 10; out_last with 10; done 1 cycle later in IDLE, after the last transfer.
- Same frame, mode 1, constant input 100 -> four outputs of 100. Then centre 255 with all neighbours 0 -> 255*4>>4 = 63.
- Mode 2: centre 200 with neighbours 10 -> clamps to 255. Centre 0 with neighbours 50 -> clamps to 0. Centre 60 with neighbours 50 -> 100.
- Mode 3 on input 0..15 -> outputs 10, 11, 14, 15. `mode` toggled mid-frame -> outputs unchanged.
- Random out_ready (50%) and in_valid gaps, IMG_W=8, IMG_H=5, mode 1 -> 18 outputs matching the reference model; no output changes while stalled.
- Assert rst after 7 accepted pixels -> all outputs return to reset values. A new `en` with a full frame -> correct outputs; no stale window data.
